mul_slow_intg: RTL and testbench

MUL_SLOW_INTG -- requirements
Module: mul_slow_intg

---
 rtl/mul_intg_pkg.sv | 44 ++++
 rtl/secded_inv_39_32_enc.sv | 25 ++
 rtl/mul_slow_intg.sv | 138 +++++++++++++
 tb/tb_mul_slow_intg.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_intg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mul_intg_pkg                                              |
// | Brief    : Shared types and constants for the slow multiplier with   |
// |            integrity-protected result (operators, FSM states, SECDED |
// |            encoder masks and inversion constant).                    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package mul_intg_pkg;

  // RISC-V M-extension multiply flavours
  typedef enum logic [1:0] {
    MUL_L   = 2'd0,  // MUL    : low word, signed x signed
    MUL_H   = 2'd1,  // MULH   : high word, signed x signed
    MUL_HSU = 2'd2,  // MULHSU : high word, signed x unsigned
    MUL_HU  = 2'd3   // MULHU  : high word, unsigned x unsigned
  } mul_op_e;

  // Multiplier control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  // Index of the final shift-add step (the multiplier sign-bit step)
  localparam logic [5:0] C_LAST_STEP = 6'd32;

  // Parity masks over the 32 data bits, one per check bit (index = check bit)
  localparam logic [6:0][31:0] C_SECDED_MASK = {
    32'h98505586,  // c6
    32'h2DCC624C,  // c5
    32'hC2C1323B,  // c4
    32'h31234ED1,  // c3
    32'h413D89AA,  // c2
    32'hDEBA8050,  // c1
    32'h2606BD25   // c0
  };

  // Check bits are inverted so an all-zero word never carries valid integrity
  localparam logic [6:0] C_SECDED_INV = 7'h2A;

endpackage
`default_nettype wire

// File: rtl/secded_inv_39_32_enc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : secded_inv_39_32_enc                                      |
// | Brief    : Combinational (39,32) SECDED encoder with inverted check  |
// |            bits. Output word is {check[6:0], data[31:0]}.            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module secded_inv_39_32_enc
  import mul_intg_pkg::*;
(
  input  logic [31:0] data_i,
  output logic [38:0] data_o
);

  logic [6:0] w_check;

  // Each check bit is the parity of its masked data bits, then inverted
  for (genvar k = 0; k < 7; k++) begin : g_check
    assign w_check[k] = (^(data_i & C_SECDED_MASK[k])) ^ C_SECDED_INV[k];
  end

  assign data_o = {w_check, data_i};

endmodule
`default_nettype wire

// File: rtl/mul_slow_intg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mul_slow_intg                                             |
// | Brief    : Iterative 33x33 shift-add multiplier (one step per cycle, |
// |            fixed 33-step latency) with SECDED-protected result.      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module mul_slow_intg
  import mul_intg_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mult_en_i,
  input  logic [1:0]  operator_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic        kill_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic [31:0] result_o,
  output logic [6:0]  result_intg_o
);

  mul_state_e  r_state;
  mul_state_e  w_state_nxt;
  mul_op_e     r_op;
  logic [65:0] r_mcand;   // multiplicand, sign-extended, shifted left each step
  logic [32:0] r_mplier;  // multiplier, shifted right each step (bit 0 = current)
  logic [65:0] r_acc;
  logic [5:0]  r_cnt;

  logic        w_busy;
  logic        w_valid;
  logic [32:0] w_a_ext;
  logic [32:0] w_b_ext;
  logic [31:0] w_result;
  logic [38:0] w_enc_word;
  logic        w_unused_bits;

  // Operand extension: only MULHU treats rs1 as unsigned; MULHSU/MULHU treat rs2 as unsigned
  assign w_a_ext = (operator_i == MUL_HU) ? {1'b0, op_a_i} : {op_a_i[31], op_a_i};
  assign w_b_ext = ((operator_i == MUL_L) || (operator_i == MUL_H)) ?
                   {op_b_i[31], op_b_i} : {1'b0, op_b_i};

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs; kill overrides everything, including DONE's valid
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_valid     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mult_en_i) w_state_nxt = ST_CALC;
      end
      ST_CALC: begin
        w_busy = 1'b1;
        if (r_cnt == C_LAST_STEP) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_busy      = 1'b1;
        w_valid     = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (kill_i) begin
      w_state_nxt = ST_IDLE;
      w_valid     = 1'b0;
    end
  end

  // Datapath: operand capture on start, one shift-add per CALC cycle.
  // The last step weighs the multiplier's sign bit, hence subtract.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_op     <= MUL_L;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (kill_i) begin
      r_op     <= MUL_L;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (mult_en_i) begin
            r_op     <= mul_op_e'(operator_i);
            r_mcand  <= {{33{w_a_ext[32]}}, w_a_ext};
            r_mplier <= w_b_ext;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        ST_CALC: begin
          if (r_mplier[0]) begin
            if (r_cnt == C_LAST_STEP) r_acc <= r_acc - r_mcand;
            else                      r_acc <= r_acc + r_mcand;
          end
          r_mcand  <= {r_mcand[64:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[32:1]};
          r_cnt    <= r_cnt + 6'd1;
        end
        default: ;
      endcase
    end
  end

  // Result is only presented in DONE so no intermediate sum ever leaks out
  assign w_result = (r_state != ST_DONE) ? 32'h0 :
                    (r_op == MUL_L)      ? r_acc[31:0] : r_acc[63:32];

  secded_inv_39_32_enc u_enc (
    .data_i (w_result),
    .data_o (w_enc_word)
  );

  // Top accumulator bits and the encoder's data echo are intentionally unused
  assign w_unused_bits = ^{r_acc[65:64], w_enc_word[31:0]};

  assign busy_o        = w_busy;
  assign valid_o       = w_valid;
  assign result_o      = w_result;
  assign result_intg_o = w_enc_word[38:32];

endmodule
`default_nettype wire

// File: tb/tb_mul_slow_intg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_mul_slow_intg                                          |
// | Brief    : Self-checking bench for mul_slow_intg: directed corner    |
// |            cases, abort/reset scenarios and random operations        |
// |            against an arithmetic reference model.                   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_mul_slow_intg;

  logic        clk;
  logic        rst_n;
  logic        mult_en;
  logic [1:0]  operator;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        kill;
  logic        busy;
  logic        valid;
  logic [31:0] result;
  logic [6:0]  result_intg;

  int n_checks = 0;
  int n_errors = 0;

  mul_slow_intg dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .mult_en_i     (mult_en),
    .operator_i    (operator),
    .op_a_i        (op_a),
    .op_b_i        (op_b),
    .kill_i        (kill),
    .busy_o        (busy),
    .valid_o       (valid),
    .result_o      (result),
    .result_intg_o (result_intg)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference product: true mathematical product of the extended operands
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [65:0] sa, sb, p;
    sa = (op == 2'd3) ? $signed({34'b0, a}) : $signed({{34{a[31]}}, a});
    sb = (op >= 2'd2) ? $signed({34'b0, b}) : $signed({{34{b[31]}}, b});
    p  = sa * sb;
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  // Reference encoder: bitwise parity over each mask, then inversion
  function automatic logic [6:0] ref_enc(input logic [31:0] d);
    logic [31:0] masks [7];
    logic [6:0]  inv;
    logic [6:0]  c;
    masks = '{32'h2606BD25, 32'hDEBA8050, 32'h413D89AA, 32'h31234ED1,
              32'hC2C1323B, 32'h2DCC624C, 32'h98505586};
    inv = 7'h2A;
    for (int k = 0; k < 7; k++) begin
      c[k] = inv[k];
      for (int j = 0; j < 32; j++) begin
        if (masks[k][j] && d[j]) c[k] = ~c[k];
      end
    end
    return c;
  endfunction

  // Runs one operation starting at the current negedge. With noise set,
  // random start requests are thrown at the busy multiplier.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit noise);
    int seen;
    mult_en  = 1'b1;
    operator = op;
    op_a     = a;
    op_b     = b;
    @(negedge clk);
    mult_en = 1'b0;
    chk({tag, ".busy"}, {63'b0, busy}, 64'd1);
    seen = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (valid) begin
        seen = k;
        break;
      end
      if (k == 5) chk({tag, ".res_idle"}, {32'b0, result}, 64'd0);
      if (noise && k < 32) begin
        mult_en  = 1'($urandom_range(0, 1));
        operator = 2'($urandom);
        op_a     = $urandom;
        op_b     = $urandom;
      end else begin
        mult_en = 1'b0;
      end
    end
    mult_en = 1'b0;
    // valid visible after edge k is sampled on edge k+1
    chk({tag, ".valid_edge"}, 64'(seen + 1), 64'd34);
    chk({tag, ".result"}, {32'b0, result}, {32'b0, exp});
    chk({tag, ".intg"}, {57'b0, result_intg}, {57'b0, ref_enc(exp)});
    @(negedge clk);
    chk({tag, ".valid_pulse"}, {62'b0, valid, busy}, 64'd0);
  endtask

  // Counts valid pulses over a window, starting at a negedge
  task automatic count_valid(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (valid) n++;
    end
  endtask

  initial begin
    int nv;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    rst_n = 1'b0; mult_en = 1'b0; operator = 2'd0; op_a = '0; op_b = '0; kill = 1'b0;
    #1;
    chk("reset.outs", {29'b0, busy, valid, result}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases
    run_op("mul_3x5", 2'd0, 32'd3, 32'd5, 32'h0000000F, 1'b0);
    run_op("mulh_min", 2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0);
    run_op("mulhu_max", 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    run_op("mulhsu_max", 2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);

    // Abort at CALC cycle 3, then a zero multiply must be clean
    mult_en = 1'b1; operator = 2'd1; op_a = 32'hAAAAA7FF; op_b = 32'h000002AA;
    @(negedge clk);
    mult_en = 1'b0;
    repeat (3) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill.busy", {63'b0, busy}, 64'd0);
    count_valid(40, nv);
    chk("kill.no_valid", 64'(nv), 64'd0);
    run_op("kill.mul_0x0", 2'd0, 32'd0, 32'd0, 32'h0, 1'b0);
    chk("kill.zero_intg", {57'b0, ref_enc(32'h0)}, 64'h2A);

    // kill and start together in IDLE: kill wins
    mult_en = 1'b1; kill = 1'b1; operator = 2'd0; op_a = 32'd9; op_b = 32'd9;
    @(negedge clk);
    mult_en = 1'b0; kill = 1'b0;
    chk("kill_prio.busy", {63'b0, busy}, 64'd0);

    // kill while in DONE suppresses that cycle's valid
    mult_en = 1'b1; operator = 2'd0; op_a = 32'd11; op_b = 32'd13;
    @(negedge clk);
    mult_en = 1'b0;
    repeat (33) @(negedge clk);
    chk("kill_done.busy", {63'b0, busy}, 64'd1);
    kill = 1'b1;
    #1;
    chk("kill_done.valid", {63'b0, valid}, 64'd0);
    @(negedge clk);
    kill = 1'b0;
    chk("kill_done.idle", {63'b0, busy}, 64'd0);

    // Reset in CALC cycle 10
    mult_en = 1'b1; operator = 2'd0; op_a = 32'h1234; op_b = 32'h5678;
    @(negedge clk);
    mult_en = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.outs", {29'b0, busy, valid, result}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_valid(40, nv);
    chk("rst_mid.no_valid", 64'(nv), 64'd0);
    // Start on the very first edge after release
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op("rst_mid.mul_7x6", 2'd0, 32'd7, 32'd6, 32'h0000002A, 1'b0);

    // Random operations with start requests hammered while busy
    for (int i = 0; i < 1000; i++) begin
      rop = 2'($urandom);
      case ($urandom_range(0, 7))
        0:       ra = 32'h80000000;
        1:       ra = 32'hFFFFFFFF;
        2:       ra = 32'h0;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 32'h80000000;
        1:       rb = 32'hFFFFFFFF;
        2:       rb = 32'h7FFFFFFF;
        default: rb = $urandom;
      endcase
      run_op("rand", rop, ra, rb, ref_mul(rop, ra, rb), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
